// File: rtl/simon_axi_pkg.sv
// Shared types for the Simon AXI FIFO bridge: AXI response codes and the
// write/read channel FSM state encodings.
package simon_axi_pkg;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10
   } resp_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_t;

endpackage

// File: rtl/simon_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags
// and an occupancy count. Push while full and pop while empty are ignored.
module simon_sync_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 512
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           din,
   input  logic                       pop,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             do_push, do_pop;

   always_comb begin
      do_push  = push & ~full_q;
      do_pop   = pop & ~empty_q;
      wr_ptr_d = wr_ptr_q + AW'(do_push);
      rd_ptr_d = rd_ptr_q + AW'(do_pop);
      level_d  = level_q + LW'(do_push) - LW'(do_pop);
      full_d   = (level_d == LW'(DEPTH));
      empty_d  = (level_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage is not reset; empty_q guards every read of stale contents.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = full_q;
   assign empty = empty_q;
   assign level = level_q;

endmodule

// File: rtl/simon_axi_fifo_bridge.sv
// AXI4 slave moving Simon cipher blocks: writes feed the ingress FIFO toward
// the core, reads drain the egress FIFO from the core.
//
//   state  | meaning
//   W_IDLE | waiting for AW; awready high
//   W_DATA | accepting W beats into ingress until WLAST
//   W_RESP | holding B response until bready
//   R_IDLE | waiting for AR; arready high
//   R_DATA | presenting egress head (or timeout beat) until RLAST handshake
module simon_axi_fifo_bridge
   import simon_axi_pkg::*;
#(
   parameter int  DATA_WIDTH = 128,
   parameter int  ADDR_WIDTH = 32,
   parameter int  LEN_WIDTH  = 8,
   parameter int  FIFO_DEPTH = 512,
   parameter int  RD_TIMEOUT = 1024,
   localparam int LVL_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                      clk,
   input  logic                      rst,

   input  logic [ADDR_WIDTH-1:0]     s_awaddr,
   input  logic [LEN_WIDTH-1:0]      s_awlen,
   input  logic                      s_awvalid,
   output logic                      s_awready,

   input  logic [DATA_WIDTH-1:0]     s_wdata,
   input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
   input  logic                      s_wlast,
   input  logic                      s_wvalid,
   output logic                      s_wready,

   output logic [1:0]                s_bresp,
   output logic                      s_bvalid,
   input  logic                      s_bready,

   input  logic [ADDR_WIDTH-1:0]     s_araddr,
   input  logic [LEN_WIDTH-1:0]      s_arlen,
   input  logic                      s_arvalid,
   output logic                      s_arready,

   output logic [DATA_WIDTH-1:0]     s_rdata,
   output logic [1:0]                s_rresp,
   output logic                      s_rlast,
   output logic                      s_rvalid,
   input  logic                      s_rready,

   output logic [DATA_WIDTH-1:0]     ingress_fifo_dout,
   output logic                      ingress_fifo_vld,
   input  logic                      ingress_fifo_rdy,

   input  logic [DATA_WIDTH-1:0]     egress_fifo_din,
   input  logic                      egress_fifo_vld,
   output logic                      egress_fifo_rdy,

   output logic [LVL_WIDTH-1:0]      ingress_level,
   output logic [LVL_WIDTH-1:0]      egress_level,
   output logic [1:0]                err_sticky
);

   localparam int              TW       = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;
   localparam logic [TW-1:0]   TMO_LOAD = TW'(RD_TIMEOUT);
   localparam bit              TMO_EN   = (RD_TIMEOUT != 0);

   wr_state_t              wr_state_q, wr_state_d;
   logic [LEN_WIDTH-1:0]   awlen_q, awlen_d;
   logic [LEN_WIDTH:0]     wcnt_q, wcnt_d;
   logic                   werr_q, werr_d;
   logic                   awready_q, awready_d;
   logic                   bvalid_q, bvalid_d;
   resp_t                  bresp_q, bresp_d;
   logic                   wr_err_set;

   rd_state_t              rd_state_q, rd_state_d;
   logic [LEN_WIDTH-1:0]   rbeats_q, rbeats_d;
   logic [TW-1:0]          tmo_q, tmo_d;
   logic                   timed_out_q, timed_out_d;
   logic                   arready_q, arready_d;
   logic                   rlast_q, rlast_d;
   logic                   tmo_set;

   logic                   live_q;
   logic [1:0]             sticky_q, sticky_d;

   logic                   ing_push, ing_pop, ing_full, ing_empty;
   logic                   eg_push, eg_pop, eg_full, eg_empty;
   logic [DATA_WIDTH-1:0]  eg_dout;
   logic                   unused_addr;

   // Addresses select nothing: the whole window maps onto the FIFOs.
   assign unused_addr = ^{s_awaddr, s_araddr};

   simon_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_ingress (
      .clk   (clk),
      .rst   (rst),
      .push  (ing_push),
      .din   (s_wdata),
      .pop   (ing_pop),
      .dout  (ingress_fifo_dout),
      .full  (ing_full),
      .empty (ing_empty),
      .level (ingress_level)
   );

   simon_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_egress (
      .clk   (clk),
      .rst   (rst),
      .push  (eg_push),
      .din   (egress_fifo_din),
      .pop   (eg_pop),
      .dout  (eg_dout),
      .full  (eg_full),
      .empty (eg_empty),
      .level (egress_level)
   );

   assign ing_pop = ingress_fifo_rdy & ~ing_empty;
   assign eg_push = egress_fifo_vld & egress_fifo_rdy;

   always_comb begin
      wr_state_d = wr_state_q;
      awlen_d    = awlen_q;
      wcnt_d     = wcnt_q;
      werr_d     = werr_q;
      ing_push   = 1'b0;
      wr_err_set = 1'b0;
      case (wr_state_q)
         W_IDLE: begin
            if (s_awvalid && awready_q) begin
               awlen_d    = s_awlen;
               wcnt_d     = '0;
               werr_d     = 1'b0;
               wr_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (s_wvalid && s_wready) begin
               if (&s_wstrb) begin
                  ing_push = 1'b1;
               end else begin
                  werr_d = 1'b1;
               end
               // Saturate so an overlong burst can never wrap back to a match.
               if (!wcnt_q[LEN_WIDTH]) begin
                  wcnt_d = wcnt_q + (LEN_WIDTH+1)'(1);
               end
               if (s_wlast) begin
                  if (wcnt_q != {1'b0, awlen_q}) begin
                     werr_d = 1'b1;
                  end
                  wr_state_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (s_bready && bvalid_q) begin
               wr_err_set = werr_q;
               wr_state_d = W_IDLE;
            end
         end
         default: wr_state_d = W_IDLE;
      endcase
      awready_d = (wr_state_d == W_IDLE);
      bvalid_d  = (wr_state_d == W_RESP);
      bresp_d   = (bvalid_d && werr_d) ? RESP_SLVERR : RESP_OKAY;
   end

   always_comb begin
      rd_state_d  = rd_state_q;
      rbeats_d    = rbeats_q;
      tmo_d       = tmo_q;
      timed_out_d = timed_out_q;
      eg_pop      = 1'b0;
      tmo_set     = 1'b0;
      case (rd_state_q)
         R_IDLE: begin
            if (s_arvalid && arready_q) begin
               rbeats_d    = s_arlen;
               tmo_d       = TMO_LOAD;
               timed_out_d = 1'b0;
               rd_state_d  = R_DATA;
            end
         end
         R_DATA: begin
            if (s_rvalid && s_rready) begin
               eg_pop      = ~timed_out_q;
               tmo_d       = TMO_LOAD;
               timed_out_d = 1'b0;
               if (rbeats_q == '0) begin
                  rd_state_d = R_IDLE;
               end else begin
                  rbeats_d = rbeats_q - LEN_WIDTH'(1);
               end
            end else if (TMO_EN && eg_empty && !timed_out_q) begin
               if (tmo_q == TW'(1)) begin
                  timed_out_d = 1'b1;
                  tmo_set     = 1'b1;
               end
               tmo_d = tmo_q - TW'(1);
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
      arready_d = (rd_state_d == R_IDLE);
      rlast_d   = (rd_state_d == R_DATA) && (rbeats_d == '0);
      sticky_d  = sticky_q | {tmo_set, wr_err_set};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_q  <= W_IDLE;
         awlen_q     <= '0;
         wcnt_q      <= '0;
         werr_q      <= 1'b0;
         awready_q   <= 1'b0;
         bvalid_q    <= 1'b0;
         bresp_q     <= RESP_OKAY;
         rd_state_q  <= R_IDLE;
         rbeats_q    <= '0;
         tmo_q       <= TMO_LOAD;
         timed_out_q <= 1'b0;
         arready_q   <= 1'b0;
         rlast_q     <= 1'b0;
         live_q      <= 1'b0;
         sticky_q    <= '0;
      end else begin
         wr_state_q  <= wr_state_d;
         awlen_q     <= awlen_d;
         wcnt_q      <= wcnt_d;
         werr_q      <= werr_d;
         awready_q   <= awready_d;
         bvalid_q    <= bvalid_d;
         bresp_q     <= bresp_d;
         rd_state_q  <= rd_state_d;
         rbeats_q    <= rbeats_d;
         tmo_q       <= tmo_d;
         timed_out_q <= timed_out_d;
         arready_q   <= arready_d;
         rlast_q     <= rlast_d;
         live_q      <= 1'b1;
         sticky_q    <= sticky_d;
      end
   end

   assign s_awready        = awready_q;
   assign s_wready         = (wr_state_q == W_DATA) & ~ing_full;
   assign s_bvalid         = bvalid_q;
   assign s_bresp          = bresp_q;
   assign s_arready        = arready_q;
   assign s_rvalid         = (rd_state_q == R_DATA) & (~eg_empty | timed_out_q);
   assign s_rlast          = rlast_q;
   // A timed-out beat keeps priority so its payload cannot change under rvalid.
   assign s_rresp          = (rd_state_q == R_DATA && timed_out_q) ? RESP_SLVERR : RESP_OKAY;
   assign s_rdata          = (rd_state_q == R_DATA && !timed_out_q) ? eg_dout : '0;
   assign ingress_fifo_vld = ~ing_empty;
   assign egress_fifo_rdy  = live_q & ~eg_full;
   assign err_sticky       = sticky_q;

endmodule

// File: tb/tb_simon_axi_fifo_bridge.sv
// Self-checking bench for simon_axi_fifo_bridge: table of write bursts plus
// hand sequences for backpressure, egress reads, read timeout and reset.
module tb_simon_axi_fifo_bridge;

   localparam int DW    = 128;
   localparam int AW    = 32;
   localparam int LW    = 8;
   localparam int DEPTH = 4;
   localparam int TMO   = 16;
   localparam int LVW   = $clog2(DEPTH) + 1;

   logic            clk, rst;
   logic [AW-1:0]   s_awaddr, s_araddr;
   logic [LW-1:0]   s_awlen, s_arlen;
   logic            s_awvalid, s_awready, s_arvalid, s_arready;
   logic [DW-1:0]   s_wdata, s_rdata;
   logic [DW/8-1:0] s_wstrb;
   logic            s_wlast, s_wvalid, s_wready;
   logic [1:0]      s_bresp, s_rresp;
   logic            s_bvalid, s_bready, s_rlast, s_rvalid, s_rready;
   logic [DW-1:0]   ingress_fifo_dout, egress_fifo_din;
   logic            ingress_fifo_vld, ingress_fifo_rdy;
   logic            egress_fifo_vld, egress_fifo_rdy;
   logic [LVW-1:0]  ingress_level, egress_level;
   logic [1:0]      err_sticky;

   simon_axi_fifo_bridge #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
      .FIFO_DEPTH(DEPTH), .RD_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst),
      .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .ingress_fifo_dout(ingress_fifo_dout), .ingress_fifo_vld(ingress_fifo_vld),
      .ingress_fifo_rdy(ingress_fifo_rdy),
      .egress_fifo_din(egress_fifo_din), .egress_fifo_vld(egress_fifo_vld),
      .egress_fifo_rdy(egress_fifo_rdy),
      .ingress_level(ingress_level), .egress_level(egress_level), .err_sticky(err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          awlen;
      int          nbeats;
      logic [15:0] strb0;
      logic [1:0]  exp_bresp;
      logic [1:0]  exp_sticky;
   } wvec_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          last;
   } rexp_t;

   int            total = 0;
   int            bad   = 0;
   logic [DW-1:0] iq[$];
   rexp_t         rq[$];
   wvec_t         vt[5];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic fail_wait(input string nm);
      total++;
      bad++;
      $display("FAIL %s: wait bound expired, got no event want event", nm);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Ingress scoreboard: compare each word the core side consumes.
   always @(negedge clk) begin
      if (!rst && ingress_fifo_vld && ingress_fifo_rdy) begin
         if (iq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL ing_extra: got word %0h want none", ingress_fifo_dout);
         end else begin
            chk("ing_data", ingress_fifo_dout, iq.pop_front());
         end
      end
   end

   // R channel scoreboard.
   always @(negedge clk) begin
      rexp_t e;
      if (!rst && s_rvalid && s_rready) begin
         if (rq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL r_extra: got beat %0h want none", s_rdata);
         end else begin
            e = rq.pop_front();
            chk("r_data", s_rdata, e.data);
            chk("r_resp", DW'(s_rresp), DW'(e.resp));
            chk("r_last", DW'(s_rlast), DW'(e.last));
         end
      end
   end

   task automatic aw_hs(input logic [LW-1:0] len);
      int n = 0;
      s_awaddr  = $urandom;
      s_awlen   = len;
      s_awvalid = 1'b1;
      while (!s_awready && n < 50) begin tick; n++; end
      if (n >= 50) fail_wait("aw_wait");
      tick;
      s_awvalid = 1'b0;
   endtask

   task automatic w_beat(input logic [DW-1:0] d, input logic [15:0] st, input logic last, input int lim);
      int n = 0;
      s_wdata  = d;
      s_wstrb  = st;
      s_wlast  = last;
      s_wvalid = 1'b1;
      if (&st) iq.push_back(d);
      while (!s_wready && n < lim) begin tick; n++; end
      if (n >= lim) fail_wait("w_wait");
      tick;
      s_wvalid = 1'b0;
      s_wlast  = 1'b0;
   endtask

   task automatic wr_burst(input int len, input int nb, input logic [15:0] strb0,
                           input logic [1:0] exp_resp, input int lim);
      aw_hs(LW'(len));
      for (int i = 0; i < nb; i++) begin
         w_beat(rnd128(), (i == 0) ? strb0 : 16'hFFFF, (i == nb - 1), lim);
      end
      chk("b_valid_after_wlast", DW'(s_bvalid), DW'(1));
      chk("b_resp", DW'(s_bresp), DW'(exp_resp));
      s_bready = 1'b1;
      tick;
      s_bready = 1'b0;
      chk("b_valid_drop", DW'(s_bvalid), DW'(0));
   endtask

   task automatic ar_hs(input logic [LW-1:0] len);
      int n = 0;
      s_araddr  = $urandom;
      s_arlen   = len;
      s_arvalid = 1'b1;
      while (!s_arready && n < 50) begin tick; n++; end
      if (n >= 50) fail_wait("ar_wait");
      tick;
      s_arvalid = 1'b0;
   endtask

   task automatic eg_push(input logic [DW-1:0] d);
      int n = 0;
      egress_fifo_din = d;
      egress_fifo_vld = 1'b1;
      while (!egress_fifo_rdy && n < 50) begin tick; n++; end
      if (n >= 50) fail_wait("eg_wait");
      tick;
      egress_fifo_vld = 1'b0;
   endtask

   task automatic wait_iq(input int lim);
      int n = 0;
      while (iq.size() != 0 && n < lim) begin tick; n++; end
      if (n >= lim) fail_wait("ing_drain");
   endtask

   task automatic wait_rq(input int lim);
      int n = 0;
      while (rq.size() != 0 && n < lim) begin tick; n++; end
      if (n >= lim) fail_wait("r_drain");
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ctl"}, DW'({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast,
                             ingress_fifo_vld, egress_fifo_rdy}), '0);
      chk({tag, "_resp"}, DW'({s_bresp, s_rresp}), '0);
      chk({tag, "_rdata"}, s_rdata, '0);
      chk({tag, "_levels"}, DW'({ingress_level, egress_level}), '0);
      chk({tag, "_sticky"}, DW'(err_sticky), '0);
   endtask

   task automatic wait_full_then_release;
      int n = 0;
      while (ingress_level != LVW'(4) && n < 100) begin tick; n++; end
      if (n >= 100) fail_wait("bp_fill");
      repeat (3) tick;
      chk("bp_wready_low", DW'(s_wready), DW'(0));
      chk("bp_level_full", DW'(ingress_level), DW'(4));
      ingress_fifo_rdy = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] d0, d1;
      int n;

      vt[0] = '{awlen: 3, nbeats: 4, strb0: 16'hFFFF, exp_bresp: 2'b00, exp_sticky: 2'b00};
      vt[1] = '{awlen: 0, nbeats: 1, strb0: 16'hFFFF, exp_bresp: 2'b00, exp_sticky: 2'b00};
      vt[2] = '{awlen: 1, nbeats: 2, strb0: 16'hFFFE, exp_bresp: 2'b10, exp_sticky: 2'b01};
      vt[3] = '{awlen: 2, nbeats: 2, strb0: 16'hFFFF, exp_bresp: 2'b10, exp_sticky: 2'b01};
      vt[4] = '{awlen: 1, nbeats: 3, strb0: 16'hFFFF, exp_bresp: 2'b10, exp_sticky: 2'b01};

      rst = 1'b1;
      s_awaddr = '0; s_awlen = '0; s_awvalid = 1'b0;
      s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
      s_araddr = '0; s_arlen = '0; s_arvalid = 1'b0; s_rready = 1'b0;
      ingress_fifo_rdy = 1'b0; egress_fifo_din = '0; egress_fifo_vld = 1'b0;

      repeat (3) tick;
      chk_reset("rst_init");
      rst = 1'b0;
      chk("awready_same_cycle", DW'(s_awready), DW'(0));
      tick;
      chk("ready_after_rst", DW'({s_awready, s_arready, egress_fifo_rdy}), DW'(3'b111));

      ingress_fifo_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         wr_burst(vt[i].awlen, vt[i].nbeats, vt[i].strb0, vt[i].exp_bresp, 20);
         chk("vec_sticky", DW'(err_sticky), DW'(vt[i].exp_sticky));
         wait_iq(20);
      end
      chk("ing_level_drained", DW'(ingress_level), DW'(0));

      ingress_fifo_rdy = 1'b0;
      fork
         wr_burst(5, 6, 16'hFFFF, 2'b00, 200);
         wait_full_then_release;
      join
      wait_iq(20);
      chk("bp_level_empty", DW'(ingress_level), DW'(0));

      d0 = rnd128();
      d1 = rnd128();
      eg_push(d0);
      eg_push(d1);
      chk("eg_level_2", DW'(egress_level), DW'(2));
      rq.push_back('{data: d0, resp: 2'b00, last: 1'b0});
      rq.push_back('{data: d1, resp: 2'b00, last: 1'b1});
      s_rready = 1'b1;
      ar_hs(LW'(1));
      wait_rq(50);
      chk("eg_level_0", DW'(egress_level), DW'(0));
      chk("arready_after_rlast", DW'(s_arready), DW'(1));
      chk("rd_sticky_clean", DW'(err_sticky), DW'(2'b01));

      rq.push_back('{data: '0, resp: 2'b10, last: 1'b1});
      ar_hs(LW'(0));
      n = 0;
      while (!s_rvalid && n < 100) begin tick; n++; end
      chk("tmo_cycles", DW'(n), DW'(TMO));
      wait_rq(10);
      chk("tmo_sticky", DW'(err_sticky), DW'(2'b11));
      chk("tmo_arready", DW'(s_arready), DW'(1));

      ingress_fifo_rdy = 1'b0;
      aw_hs(LW'(3));
      w_beat(rnd128(), 16'hFFFF, 1'b0, 20);
      w_beat(rnd128(), 16'hFFFF, 1'b0, 20);
      chk("mid_level_2", DW'(ingress_level), DW'(2));
      rst = 1'b1;
      tick;
      chk_reset("rst_mid");
      iq.delete();
      rst = 1'b0;
      chk("mid_awready_low", DW'(s_awready), DW'(0));
      tick;
      chk("mid_awready_high", DW'(s_awready), DW'(1));

      ingress_fifo_rdy = 1'b1;
      wr_burst(0, 1, 16'hFFFF, 2'b00, 20);
      wait_iq(20);

      chk("iq_empty", DW'(iq.size()), DW'(0));
      chk("rq_empty", DW'(rq.size()), DW'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
